// File: rtl/time_keeper.sv
// BCD time-of-day keeper (hh:mm:ss) advanced by rising edges of clk_1Hz, with validated loads and event strobes.
// Optional alarm comparator compiled in with TIME_KEEPER_ALARM_EN; without it alarm is tied low.
module time_keeper #(
   parameter bit RUN_AT_RESET = 1'b1
) (
   input  logic        clk_2MHz,
   input  logic        reset,
   input  logic        clk_1Hz,
   input  logic        run,
   input  logic        load_en,
   input  logic [23:0] load_time,
   input  logic [23:0] alarm_time,
   input  logic        alarm_arm,
   input  logic        alarm_ack,
   output logic [7:0]  hh_bcd,
   output logic [7:0]  mm_bcd,
   output logic [7:0]  ss_bcd,
   output logic        sec_pulse,
   output logic        min_pulse,
   output logic        hour_pulse,
   output logic        day_pulse,
   output logic        load_err,
   output logic        alarm
);

   logic [7:0] hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
   logic       tick_d_q;
   logic       run_en_q, run_en_d;
   logic       sec_q, sec_d, min_q, min_d, hour_q, hour_d, day_q, day_d;
   logic       load_err_q, load_err_d;

   logic       tick, counted, load_ok;
   logic       wrap_s, wrap_m, wrap_h;
   logic [7:0] hh_inc, mm_inc, ss_inc;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v[3:0] == 4'd9) bcd_inc = {v[7:4] + 4'd1, 4'd0};
      else                bcd_inc = {v[7:4], v[3:0] + 4'd1};
   endfunction

   always_comb begin
      tick    = clk_1Hz & ~tick_d_q;
      // A load in the same cycle swallows the tick entirely.
      counted = tick & run & run_en_q & ~load_en;
      wrap_s  = (ss_q == 8'h59);
      wrap_m  = (mm_q == 8'h59);
      wrap_h  = (hh_q == 8'h23);
      ss_inc  = wrap_s ? 8'h00 : bcd_inc(ss_q);
      mm_inc  = wrap_s ? (wrap_m ? 8'h00 : bcd_inc(mm_q)) : mm_q;
      hh_inc  = (wrap_s & wrap_m) ? (wrap_h ? 8'h00 : bcd_inc(hh_q)) : hh_q;

      load_ok = (load_time[23:16] <= 8'h23) && (load_time[19:16] <= 4'd9) &&
                (load_time[15:12] <= 4'd5)  && (load_time[11:8]  <= 4'd9) &&
                (load_time[7:4]   <= 4'd5)  && (load_time[3:0]   <= 4'd9);

      hh_d       = hh_q;
      mm_d       = mm_q;
      ss_d       = ss_q;
      run_en_d   = run_en_q;
      sec_d      = 1'b0;
      min_d      = 1'b0;
      hour_d     = 1'b0;
      day_d      = 1'b0;
      load_err_d = 1'b0;

      if (load_en) begin
         if (load_ok) begin
            {hh_d, mm_d, ss_d} = load_time;
            run_en_d           = 1'b1;
         end else begin
            load_err_d = 1'b1;
         end
      end else if (counted) begin
         hh_d   = hh_inc;
         mm_d   = mm_inc;
         ss_d   = ss_inc;
         sec_d  = 1'b1;
         min_d  = wrap_s;
         hour_d = wrap_s & wrap_m;
         day_d  = wrap_s & wrap_m & wrap_h;
      end
   end

   always_ff @(posedge clk_2MHz) begin
      // Edge detector follows clk_1Hz even in reset so a high level at release is not a tick.
      tick_d_q <= clk_1Hz;
      if (reset) begin
         hh_q       <= 8'h00;
         mm_q       <= 8'h00;
         ss_q       <= 8'h00;
         run_en_q   <= RUN_AT_RESET;
         sec_q      <= 1'b0;
         min_q      <= 1'b0;
         hour_q     <= 1'b0;
         day_q      <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         hh_q       <= hh_d;
         mm_q       <= mm_d;
         ss_q       <= ss_d;
         run_en_q   <= run_en_d;
         sec_q      <= sec_d;
         min_q      <= min_d;
         hour_q     <= hour_d;
         day_q      <= day_d;
         load_err_q <= load_err_d;
      end
   end

   assign hh_bcd     = hh_q;
   assign mm_bcd     = mm_q;
   assign ss_bcd     = ss_q;
   assign sec_pulse  = sec_q;
   assign min_pulse  = min_q;
   assign hour_pulse = hour_q;
   assign day_pulse  = day_q;
   assign load_err   = load_err_q;

`ifdef TIME_KEEPER_ALARM_EN
   logic arm_q, arm_d, alarm_q, alarm_d;

   always_comb begin
      arm_d = alarm_arm;
      // Match only on counted ticks; a fresh match wins over a same-cycle ack.
      if (counted && alarm_arm && arm_q && ({hh_inc, mm_inc, ss_inc} == alarm_time))
         alarm_d = 1'b1;
      else if (alarm_ack || !alarm_arm)
         alarm_d = 1'b0;
      else
         alarm_d = alarm_q;
   end

   always_ff @(posedge clk_2MHz) begin
      if (reset) begin
         arm_q   <= 1'b0;
         alarm_q <= 1'b0;
      end else begin
         arm_q   <= arm_d;
         alarm_q <= alarm_d;
      end
   end

   assign alarm = alarm_q;
`else
   logic unused_alarm_inputs;
   assign unused_alarm_inputs = ^{alarm_time, alarm_arm, alarm_ack};
   assign alarm = 1'b0;
`endif

endmodule
